// File: rtl/pixel_stream_stats.sv
// pixel_stream_stats
//
// Collects per-frame pixel statistics (min, max, sum) from a packed pixel
// stream and publishes them once the sensor signals end of frame. The block
// tracks the position of the next expected word and flags frames that end
// early (short) or that deliver words after the last pixel (long).
//
// Parameters
//   PIXEL_BITS   bits per pixel
//   BUS_WIDTH    pixels per input word
//   ARRAY_WIDTH  pixels per row, must be a multiple of BUS_WIDTH
//   ARRAY_HEIGHT rows per frame
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RESET          asynchronous active-low reset
//   IN_VALID       qualifies IN_DATA for one cycle
//   IN_DATA        BUS_WIDTH lanes, lane 0 in the low bits is the leftmost pixel
//   FRAME_FINISHED level from the sensor, a rising edge marks end of frame
//   COL_IDX        column of lane 0 of the next expected word
//   ROW_IDX        row of the next expected word
//   ROW_END        one-cycle pulse after the last word of a row is accepted
//   STATS_VALID    one-cycle pulse when the statistics outputs update
//   PIX_MIN        minimum pixel of the last closed frame
//   PIX_MAX        maximum pixel of the last closed frame
//   PIX_SUM        sum of all pixels of the last closed frame
//   ERR_SHORT      last closed frame ended before its final word
//   ERR_LONG       last closed frame received words after its final word

module pixel_stream_stats #(
  parameter int unsigned PIXEL_BITS   = 8,
  parameter int unsigned BUS_WIDTH    = 4,
  parameter int unsigned ARRAY_WIDTH  = 128,
  parameter int unsigned ARRAY_HEIGHT = 128,
  localparam int unsigned COL_W  = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1,
  localparam int unsigned ROW_W  = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1,
  localparam int unsigned SUM_W  = PIXEL_BITS + $clog2(ARRAY_WIDTH * ARRAY_HEIGHT),
  localparam int unsigned DATA_W = BUS_WIDTH * PIXEL_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [DATA_W-1:0]     IN_DATA,
  input  logic                  FRAME_FINISHED,
  output logic [COL_W-1:0]      COL_IDX,
  output logic [ROW_W-1:0]      ROW_IDX,
  output logic                  ROW_END,
  output logic                  STATS_VALID,
  output logic [PIXEL_BITS-1:0] PIX_MIN,
  output logic [PIXEL_BITS-1:0] PIX_MAX,
  output logic [SUM_W-1:0]      PIX_SUM,
  output logic                  ERR_SHORT,
  output logic                  ERR_LONG
);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWaitFf,
    StClose
  } state_e;

  localparam logic [COL_W-1:0] ColLast = COL_W'(ARRAY_WIDTH - BUS_WIDTH);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(ARRAY_HEIGHT - 1);

  state_e state_q, state_d;

  logic                  ff_q;
  logic                  ff_edge;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;

  logic [PIXEL_BITS-1:0] acc_min_q, acc_min_d;
  logic [PIXEL_BITS-1:0] acc_max_q, acc_max_d;
  logic [SUM_W-1:0]      acc_sum_q, acc_sum_d;
  logic                  short_q, short_d;
  logic                  long_q, long_d;

  logic                  row_end_q, row_end_d;
  logic                  stats_valid_q, stats_valid_d;
  logic [PIXEL_BITS-1:0] pix_min_q, pix_min_d;
  logic [PIXEL_BITS-1:0] pix_max_q, pix_max_d;
  logic [SUM_W-1:0]      pix_sum_q, pix_sum_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;

  // Per-word reduction of all lanes
  logic [PIXEL_BITS-1:0] lane;
  logic [PIXEL_BITS-1:0] word_min;
  logic [PIXEL_BITS-1:0] word_max;
  logic [SUM_W-1:0]      word_sum;

  logic accept;
  logic col_last;
  logic row_last;
  logic word_last;

  // The edge compares the live pin with its single registered sample, so the
  // closing edge enters StClose on the first clock that sees it.
  assign ff_edge = FRAME_FINISHED & ~ff_q;

  // Words are only taken while a frame is open; StWaitFf and StClose drop them.
  assign accept    = IN_VALID & ((state_q == StIdle) | (state_q == StRecv));
  assign col_last  = (col_q == ColLast);
  assign row_last  = (row_q == RowLast);
  assign word_last = accept & col_last & row_last;

  always_comb begin
    lane     = '0;
    word_min = '1;
    word_max = '0;
    word_sum = '0;
    for (int k = 0; k < int'(BUS_WIDTH); k++) begin
      lane = IN_DATA[k*PIXEL_BITS +: PIXEL_BITS];
      if (lane < word_min) word_min = lane;
      if (lane > word_max) word_max = lane;
      word_sum = word_sum + SUM_W'(lane);
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    acc_min_d     = acc_min_q;
    acc_max_d     = acc_max_q;
    acc_sum_d     = acc_sum_q;
    short_d       = short_q;
    long_d        = long_q;
    row_end_d     = 1'b0;
    stats_valid_d = 1'b0;
    pix_min_d     = pix_min_q;
    pix_max_d     = pix_max_q;
    pix_sum_d     = pix_sum_q;
    err_short_d   = err_short_q;
    err_long_d    = err_long_q;

    // Fold the word and advance the position whenever a word is accepted
    if (accept) begin
      if (word_min < acc_min_q) acc_min_d = word_min;
      if (word_max > acc_max_q) acc_max_d = word_max;
      acc_sum_d = acc_sum_q + word_sum;
      if (col_last) begin
        col_d     = '0;
        row_d     = row_last ? '0 : row_q + ROW_W'(1);
        row_end_d = 1'b1;
      end else begin
        col_d = col_q + COL_W'(BUS_WIDTH);
      end
    end

    unique case (state_q)
      StIdle: begin
        // An end-of-frame edge with no frame open is ignored; a word opens
        // the frame and is then handled exactly as in StRecv.
        if (IN_VALID) begin
          if (ff_edge) begin
            state_d = StClose;
            if (!word_last) short_d = 1'b1;
          end else if (word_last) begin
            state_d = StWaitFf;
          end else begin
            state_d = StRecv;
          end
        end
      end

      StRecv: begin
        if (ff_edge) begin
          // Closing on the last word itself is a complete frame
          state_d = StClose;
          if (!word_last) short_d = 1'b1;
        end else if (word_last) begin
          state_d = StWaitFf;
        end
      end

      StWaitFf: begin
        if (IN_VALID) long_d = 1'b1;
        if (ff_edge) state_d = StClose;
      end

      StClose: begin
        pix_min_d     = acc_min_q;
        pix_max_d     = acc_max_q;
        pix_sum_d     = acc_sum_q;
        err_short_d   = short_q;
        err_long_d    = long_q;
        stats_valid_d = 1'b1;
        acc_min_d     = '1;
        acc_max_d     = '0;
        acc_sum_d     = '0;
        col_d         = '0;
        row_d         = '0;
        short_d       = 1'b0;
        long_d        = 1'b0;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      ff_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      acc_min_q     <= '1;
      acc_max_q     <= '0;
      acc_sum_q     <= '0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      row_end_q     <= 1'b0;
      stats_valid_q <= 1'b0;
      pix_min_q     <= '0;
      pix_max_q     <= '0;
      pix_sum_q     <= '0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ff_q          <= FRAME_FINISHED;
      col_q         <= col_d;
      row_q         <= row_d;
      acc_min_q     <= acc_min_d;
      acc_max_q     <= acc_max_d;
      acc_sum_q     <= acc_sum_d;
      short_q       <= short_d;
      long_q        <= long_d;
      row_end_q     <= row_end_d;
      stats_valid_q <= stats_valid_d;
      pix_min_q     <= pix_min_d;
      pix_max_q     <= pix_max_d;
      pix_sum_q     <= pix_sum_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
    end
  end

  assign COL_IDX     = col_q;
  assign ROW_IDX     = row_q;
  assign ROW_END     = row_end_q;
  assign STATS_VALID = stats_valid_q;
  assign PIX_MIN     = pix_min_q;
  assign PIX_MAX     = pix_max_q;
  assign PIX_SUM     = pix_sum_q;
  assign ERR_SHORT   = err_short_q;
  assign ERR_LONG    = err_long_q;

endmodule

// File: tb/tb_pixel_stream_stats.sv
// Testbench for pixel_stream_stats: a directed vector table, hand-written
// frame sequences and randomized frames, all checked against a frame-level
// reference model that counts accepted words and folds pixels arithmetically.

module tb_pixel_stream_stats;

  localparam int PB    = 8;
  localparam int BW    = 4;
  localparam int AW    = 128;
  localparam int AH    = 128;
  localparam int WPR   = AW / BW;
  localparam int TOTAL = WPR * AH;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic [31:0] IN_DATA;
  logic        FRAME_FINISHED;
  logic [6:0]  COL_IDX;
  logic [6:0]  ROW_IDX;
  logic        ROW_END;
  logic        STATS_VALID;
  logic [7:0]  PIX_MIN;
  logic [7:0]  PIX_MAX;
  logic [21:0] PIX_SUM;
  logic        ERR_SHORT;
  logic        ERR_LONG;

  pixel_stream_stats #(
    .PIXEL_BITS  (PB),
    .BUS_WIDTH   (BW),
    .ARRAY_WIDTH (AW),
    .ARRAY_HEIGHT(AH)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IN_VALID      (IN_VALID),
    .IN_DATA       (IN_DATA),
    .FRAME_FINISHED(FRAME_FINISHED),
    .COL_IDX       (COL_IDX),
    .ROW_IDX       (ROW_IDX),
    .ROW_END       (ROW_END),
    .STATS_VALID   (STATS_VALID),
    .PIX_MIN       (PIX_MIN),
    .PIX_MAX       (PIX_MAX),
    .PIX_SUM       (PIX_SUM),
    .ERR_SHORT     (ERR_SHORT),
    .ERR_LONG      (ERR_LONG)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_words;      // words accepted in the open frame (capped at TOTAL)
  bit     m_long;
  int     m_min, m_max;
  longint m_sum;
  bit     m_in_close;   // the next clock publishes the pending stats
  bit     m_ff_prev;
  bit     m_row_end;
  bit     m_sv;
  int     p_min, p_max;
  longint p_sum;
  bit     p_short, p_long;
  int     e_min, e_max;
  longint e_sum;
  bit     e_short, e_long;
  int     sv_count;
  int     row_end_count;

  task automatic model_clear_frame();
    m_words = 0;
    m_long  = 0;
    m_min   = (1 << PB) - 1;
    m_max   = 0;
    m_sum   = 0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    m_in_close = 0;
    m_ff_prev  = 0;
    m_row_end  = 0;
    m_sv       = 0;
    e_min = 0; e_max = 0; e_sum = 0; e_short = 0; e_long = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit f);
    bit edge_seen;
    int px;
    IN_VALID       = v;
    IN_DATA        = d;
    FRAME_FINISHED = f;
    @(posedge CLK);
    edge_seen = f && !m_ff_prev;
    m_ff_prev = f;
    m_row_end = 0;
    m_sv      = 0;
    if (m_in_close) begin
      m_in_close = 0;
      m_sv    = 1;
      e_min   = p_min;  e_max  = p_max;  e_sum = p_sum;
      e_short = p_short; e_long = p_long;
      model_clear_frame();
    end else begin
      if (v) begin
        if (m_words < TOTAL) begin
          for (int k = 0; k < BW; k++) begin
            px = int'(d[k*PB +: PB]);
            if (px < m_min) m_min = px;
            if (px > m_max) m_max = px;
            m_sum += px;
          end
          m_words++;
          if (m_words % WPR == 0) m_row_end = 1;
        end else begin
          m_long = 1;
        end
      end
      if (edge_seen && m_words > 0) begin
        p_min   = m_min;  p_max  = m_max;  p_sum = m_sum;
        p_short = (m_words < TOTAL);
        p_long  = m_long;
        m_in_close = 1;
      end
    end
    #1;
    chk("stats_valid", STATS_VALID, m_sv);
    chk("row_end", ROW_END, m_row_end);
    chk("col_idx", COL_IDX, 64'((m_words % WPR) * BW));
    chk("row_idx", ROW_IDX, 64'((m_words / WPR) % AH));
    if (m_sv) begin
      chk("pix_min", PIX_MIN, 64'(e_min));
      chk("pix_max", PIX_MAX, 64'(e_max));
      chk("pix_sum", PIX_SUM, 64'(e_sum));
      chk("err_short", ERR_SHORT, e_short);
      chk("err_long", ERR_LONG, e_long);
    end
    if (STATS_VALID) sv_count++;
    if (ROW_END) row_end_count++;
  endtask

  task automatic do_reset();
    RESET          = 1'b0;
    IN_VALID       = 1'b0;
    IN_DATA        = '0;
    FRAME_FINISHED = 1'b0;
    #1;
    chk("rst_col", COL_IDX, 0);
    chk("rst_row", ROW_IDX, 0);
    chk("rst_row_end", ROW_END, 0);
    chk("rst_sv", STATS_VALID, 0);
    chk("rst_min", PIX_MIN, 0);
    chk("rst_max", PIX_MAX, 0);
    chk("rst_sum", PIX_SUM, 0);
    chk("rst_short", ERR_SHORT, 0);
    chk("rst_long", ERR_LONG, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  // pattern 0: (col+row) mod 256, 1: all 0xFF, 2: random
  function automatic logic [31:0] make_word(input int idx, input int pattern);
    logic [31:0] w;
    int r, c;
    r = idx / WPR;
    c = (idx % WPR) * BW;
    w = '0;
    for (int k = 0; k < BW; k++) begin
      case (pattern)
        0:       w[k*PB +: PB] = 8'((c + k + r) & 255);
        1:       w[k*PB +: PB] = 8'hFF;
        default: w[k*PB +: PB] = 8'($urandom_range(0, 255));
      endcase
    end
    return w;
  endfunction

  task automatic send_frame(input int n, input int pattern, input bit ff_on_last,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) step(0, $urandom, 0);
      step(1, make_word(i, pattern), ff_on_last && (i == n - 1));
    end
  endtask

  task automatic close_frame(input bit noisy);
    step(noisy && $urandom_range(0, 1) == 1, $urandom, 1);
    step(noisy && $urandom_range(0, 1) == 1, $urandom, 1);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          f;
    int          col;
    int          row;
    bit          sv;
    int          mn;
    int          mx;
    int          sum;
    bit          es;
    bit          el;
  } vec_t;

  vec_t vecs[10];
  int   sv0, re0;
  int   n_words;
  int   kind;

  initial begin
    RESET = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = '0;
    FRAME_FINISHED = 1'b0;
    sv_count = 0;
    row_end_count = 0;

    // ---- table-driven vectors, applied straight after reset ----
    vecs[0] = '{0, 32'h0,        1, 0, 0, 0, 0,   0,   0,   0, 0}; // edge in idle ignored
    vecs[1] = '{0, 32'h0,        0, 0, 0, 0, 0,   0,   0,   0, 0};
    vecs[2] = '{1, 32'h04030201, 0, 4, 0, 0, 0,   0,   0,   0, 0};
    vecs[3] = '{0, 32'h0,        0, 4, 0, 0, 0,   0,   0,   0, 0};
    vecs[4] = '{1, 32'h40302010, 0, 8, 0, 0, 0,   0,   0,   0, 0};
    vecs[5] = '{0, 32'h0,        1, 8, 0, 0, 0,   0,   0,   0, 0}; // short close
    vecs[6] = '{1, 32'hFFFFFFFF, 1, 0, 0, 1, 1,   64,  170, 1, 0}; // dropped in close
    vecs[7] = '{0, 32'h0,        0, 0, 0, 0, 0,   0,   0,   0, 0};
    vecs[8] = '{1, 32'h000000AB, 1, 4, 0, 0, 0,   0,   0,   0, 0}; // open+close at once
    vecs[9] = '{0, 32'h0,        0, 0, 0, 1, 0,   171, 171, 1, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      IN_VALID       = vecs[i].v;
      IN_DATA        = vecs[i].d;
      FRAME_FINISHED = vecs[i].f;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_col", i), COL_IDX, 64'(vecs[i].col));
      chk($sformatf("vec%0d_row", i), ROW_IDX, 64'(vecs[i].row));
      chk($sformatf("vec%0d_sv", i), STATS_VALID, vecs[i].sv);
      if (vecs[i].sv) begin
        chk($sformatf("vec%0d_min", i), PIX_MIN, 64'(vecs[i].mn));
        chk($sformatf("vec%0d_max", i), PIX_MAX, 64'(vecs[i].mx));
        chk($sformatf("vec%0d_sum", i), PIX_SUM, 64'(vecs[i].sum));
        chk($sformatf("vec%0d_short", i), ERR_SHORT, vecs[i].es);
        chk($sformatf("vec%0d_long", i), ERR_LONG, vecs[i].el);
      end
    end

    // ---- full gradient frame ----
    do_reset();
    sv0 = sv_count;
    send_frame(TOTAL, 0, 0, 0);
    close_frame(0);
    chk("grad_sv_count", sv_count - sv0, 1);
    chk("grad_min", PIX_MIN, 0);
    chk("grad_max", PIX_MAX, 254);
    chk("grad_sum", PIX_SUM, 2080768);
    chk("grad_short", ERR_SHORT, 0);
    chk("grad_long", ERR_LONG, 0);

    // ---- all-ones frame closed on the last-word cycle ----
    sv0 = sv_count;
    send_frame(TOTAL, 1, 1, 0);
    close_frame(0);
    chk("ones_sv_count", sv_count - sv0, 1);
    chk("ones_sum", PIX_SUM, 4177920);
    chk("ones_min", PIX_MIN, 255);
    chk("ones_max", PIX_MAX, 255);
    chk("ones_short", ERR_SHORT, 0);
    chk("ones_long", ERR_LONG, 0);

    // ---- short frame of 100 words ----
    send_frame(100, 2, 0, 0);
    chk("short_pre_sum", m_sum, m_sum);
    close_frame(0);
    chk("short_err", ERR_SHORT, 1);
    chk("short_long", ERR_LONG, 0);

    // ---- long frame: 3 extra words ----
    send_frame(TOTAL, 2, 0, 0);
    p_sum = m_sum;
    step(1, 32'hFFFFFFFF, 0);
    step(1, 32'hFFFFFFFF, 0);
    step(1, 32'hFFFFFFFF, 0);
    chk("long_col", COL_IDX, 0);
    chk("long_row", ROW_IDX, 0);
    close_frame(0);
    chk("long_err", ERR_LONG, 1);
    chk("long_short", ERR_SHORT, 0);
    chk("long_sum", PIX_SUM, 64'(p_sum));

    // ---- reset in mid-frame, then a full frame ----
    send_frame(2000, 2, 0, 0);
    do_reset();
    sv0 = sv_count;
    re0 = row_end_count;
    send_frame(TOTAL, 0, 0, 1);
    close_frame(0);
    chk("rst_frame_sv_count", sv_count - sv0, 1);
    chk("rst_frame_row_ends", row_end_count - re0, 128);
    chk("rst_frame_sum", PIX_SUM, 2080768);

    // ---- randomized frames ----
    for (int f = 0; f < 4; f++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       n_words = $urandom_range(1, 200);
        1:       n_words = TOTAL;
        default: n_words = TOTAL + $urandom_range(1, 3);
      endcase
      sv0 = sv_count;
      send_frame(n_words, 2, (kind == 1) && ($urandom_range(0, 1) == 1), 1);
      close_frame(1);
      chk("rand_sv_count", sv_count - sv0, 1);
    end

    repeat (5) step(0, $urandom, 0);
    chk("hold_sum", PIX_SUM, 64'(e_sum));
    chk("hold_min", PIX_MIN, 64'(e_min));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
